// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM states, byte/word
// geometry and the default frame start marker.
package loader_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 2;
  localparam int unsigned WORD_W         = BYTE_W * BYTES_PER_WORD;
  localparam int unsigned LEN_W          = 2 * BYTE_W;

  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LEN_HI  = 4'd1,
    LEN_LO  = 4'd2,
    DATA_HI = 4'd3,
    DATA_LO = 4'd4,
    WRITE   = 4'd5,
    CHECK   = 4'd6,
    DONE    = 4'd7,
    ERROR   = 4'd8
  } state_e;

endpackage

// File: rtl/loader_checksum.sv
// Running XOR over accepted frame bytes; clear has priority over enable.
module loader_checksum
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] sum
);

  logic [BYTE_W-1:0] sum_q;
  logic [BYTE_W-1:0] sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (en) begin
      sum_d = sum_q ^ din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader for the instruction memory; holds the CPU until an
// image is complete. Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing CHK byte.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       DATA_W    = 16,
  parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  state_e              state_q, state_d;
  logic                rx_ready_q, rx_ready_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                done_q, done_d;
  logic [BYTE_W-1:0]   hi_byte_q, hi_byte_d;
  logic [LEN_W-1:0]    remaining_q, remaining_d;

  logic                accept_c;
  logic                sync_hit_c;
  logic                frame_end_c;
  logic [WORD_W-1:0]   word_c;

  assign accept_c   = rx_valid && rx_ready_q;
  assign sync_hit_c = accept_c && (rx_data == SYNC_BYTE);
  assign word_c     = {hi_byte_q, rx_data};

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic              error_q, error_d;
  logic              sum_clr_c;
  logic              sum_en_c;
  logic [BYTE_W-1:0] sum_c;

  // Length and data bytes feed the checksum; SYNC starts a fresh one.
  assign sum_clr_c = sync_hit_c &&
                     ((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));
  assign sum_en_c  = accept_c &&
                     ((state_q == LEN_HI) || (state_q == LEN_LO) ||
                      (state_q == DATA_HI) || (state_q == DATA_LO));

  loader_checksum u_checksum (
    .clk   (clock),
    .rst_n (reset_n),
    .clr   (sum_clr_c),
    .en    (sum_en_c),
    .din   (rx_data),
    .sum   (sum_c)
  );
`endif

  always_comb begin
    state_d     = state_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    done_d      = done_q;
    hi_byte_d   = hi_byte_q;
    remaining_d = remaining_q;
    frame_end_c = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    error_d     = error_q;
`endif

    unique case (state_q)
      // Idle and terminal states only react to SYNC; any other byte is dropped.
      IDLE, DONE, ERROR: begin
        if (sync_hit_c) begin
          state_d    = LEN_HI;
          done_d     = 1'b0;
          cpu_hold_d = 1'b1;
          mem_addr_d = BASE_ADDR;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          error_d    = 1'b0;
`endif
        end
      end
      LEN_HI: begin
        if (accept_c) begin
          hi_byte_d = rx_data;
          state_d   = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept_c) begin
          remaining_d = LEN_W'(word_c);
          if (word_c == '0) begin
            frame_end_c = 1'b1;
          end else begin
            state_d = DATA_HI;
          end
        end
      end
      DATA_HI: begin
        if (accept_c) begin
          hi_byte_d = rx_data;
          state_d   = DATA_LO;
        end
      end
      DATA_LO: begin
        if (accept_c) begin
          mem_wdata_d = DATA_W'(word_c);
          mem_we_d    = 1'b1;
          state_d     = WRITE;
        end
      end
      // mem_we is high for this cycle; the address advances as it ends.
      WRITE: begin
        mem_addr_d  = mem_addr_q + ADDR_W'(1);
        remaining_d = remaining_q - LEN_W'(1);
        if (remaining_q == LEN_W'(1)) begin
          frame_end_c = 1'b1;
        end else begin
          state_d = DATA_HI;
        end
      end
      CHECK: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if (accept_c) begin
          if (rx_data == sum_c) begin
            state_d    = DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d    = ERROR;
            error_d    = 1'b1;
          end
        end
`else
        state_d = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (frame_end_c) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      state_d    = CHECK;
`else
      state_d    = DONE;
      done_d     = 1'b1;
      cpu_hold_d = 1'b0;
`endif
    end
  end

  // The WRITE cycle is the only one that refuses bytes.
  assign rx_ready_d = (state_d != WRITE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rx_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      hi_byte_q   <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      rx_ready_q  <= rx_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      hi_byte_q   <= hi_byte_d;
      remaining_q <= remaining_d;
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign rx_ready  = rx_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed, table-driven bench for program_loader; works with or without
// PROGRAM_LOADER_CHECKSUM_EN defined.
module tb_program_loader;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  program_loader dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  rx;
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
    logic        dn;
    logic        hold;
    logic        err;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;
  int   wr_cnt = 0;
  int   w0;

  // Counts write strobes as seen by the memory at each rising edge.
  always @(posedge clock) begin
    if (mem_we) wr_cnt <= wr_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] rx, input logic we, input logic [15:0] a,
                     input logic [15:0] d, input logic dn, input logic hold, input logic err);
    vec_t v;
    v.rx = rx; v.we = we; v.addr = a; v.data = d; v.dn = dn; v.hold = hold; v.err = err;
    vq.push_back(v);
  endtask

  // Present one byte for exactly one accepting edge; returns at the following negedge.
  task automatic send_byte(input logic [7:0] b, output bit ok);
    int n;
    n = 0;
    @(negedge clock);
    while (!rx_ready && n < 64) begin
      @(negedge clock);
      n++;
    end
    ok = rx_ready;
    if (ok) begin
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clock);
      rx_valid = 1'b0;
    end
  endtask

  task automatic run_vecs(input string tag, input int gap);
    bit ok;
    foreach (vq[i]) begin
      repeat (gap) @(negedge clock);
      send_byte(vq[i].rx, ok);
      chk($sformatf("%s[%0d] accepted", tag, i), 32'(ok), 32'd1);
      chk($sformatf("%s[%0d] mem_we", tag, i), 32'(mem_we), 32'(vq[i].we));
      if (vq[i].we) begin
        chk($sformatf("%s[%0d] mem_addr", tag, i), 32'(mem_addr), 32'(vq[i].addr));
        chk($sformatf("%s[%0d] mem_wdata", tag, i), 32'(mem_wdata), 32'(vq[i].data));
      end
      chk($sformatf("%s[%0d] done", tag, i), 32'(done), 32'(vq[i].dn));
      chk($sformatf("%s[%0d] cpu_hold", tag, i), 32'(cpu_hold), 32'(vq[i].hold));
      chk($sformatf("%s[%0d] error", tag, i), 32'(error), 32'(vq[i].err));
    end
    vq.delete();
  endtask

  task automatic post(input string tag, input logic dn, input logic hold, input logic err);
    @(negedge clock);
    chk({tag, " post mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, " post done"}, 32'(done), 32'(dn));
    chk({tag, " post cpu_hold"}, 32'(cpu_hold), 32'(hold));
    chk({tag, " post error"}, 32'(error), 32'(err));
  endtask

  // Two-word frame C01F, 1234; the CHK byte is only sent when checksums are enabled.
  task automatic build_good(input logic good_chk);
    logic [7:0] x;
    logic [7:0] c;
    x = 8'h00 ^ 8'h02 ^ 8'hC0 ^ 8'h1F ^ 8'h12 ^ 8'h34;
    c = good_chk ? x : ~x;
    add(8'hA5, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    add(8'h00, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    add(8'h02, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    add(8'hC0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    add(8'h1F, 1'b1, 16'h0000, 16'hC01F, 1'b0, 1'b1, 1'b0);
    add(8'h12, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    add(8'h34, 1'b1, 16'h0001, 16'h1234, 1'b0, 1'b1, 1'b0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    add(c, 1'b0, 16'h0000, 16'h0000, good_chk, ~good_chk, ~good_chk);
`else
    if (c == 8'h00) add(8'h00, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
`endif
  endtask

  // One-word frame ABCD.
  task automatic build_one();
    add(8'hA5, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    add(8'h00, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    add(8'h01, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    add(8'hAB, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    add(8'hCD, 1'b1, 16'h0000, 16'hABCD, 1'b0, 1'b1, 1'b0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    add(8'h00 ^ 8'h01 ^ 8'hAB ^ 8'hCD, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
`endif
  endtask

  initial begin
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clock);
    chk("reset rx_ready", 32'(rx_ready), 32'd0);
    chk("reset mem_we", 32'(mem_we), 32'd0);
    chk("reset mem_addr", 32'(mem_addr), 32'h0000);
    chk("reset mem_wdata", 32'(mem_wdata), 32'h0000);
    chk("reset cpu_hold", 32'(cpu_hold), 32'd1);
    chk("reset done", 32'(done), 32'd0);
    chk("reset error", 32'(error), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("release rx_ready", 32'(rx_ready), 32'd1);

    // Leading garbage then a zero-length frame.
    add(8'h55, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    add(8'hA5, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    add(8'h00, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    add(8'h00, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    add(8'h00, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
`else
    add(8'h00, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
`endif
    w0 = wr_cnt;
    run_vecs("zero", 0);
    post("zero", 1'b1, 1'b0, 1'b0);
    chk("zero writes", 32'(wr_cnt - w0), 32'd0);

    w0 = wr_cnt;
    build_good(1'b1);
    run_vecs("good", 0);
    post("good", 1'b1, 1'b0, 1'b0);
    chk("good writes", 32'(wr_cnt - w0), 32'd2);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    w0 = wr_cnt;
    build_good(1'b0);
    run_vecs("badchk", 0);
    post("badchk", 1'b0, 1'b1, 1'b1);
    chk("badchk writes", 32'(wr_cnt - w0), 32'd2);
    build_good(1'b1);
    run_vecs("recover", 0);
    post("recover", 1'b1, 1'b0, 1'b0);
`endif

    w0 = wr_cnt;
    build_good(1'b1);
    run_vecs("gap", 3);
    post("gap", 1'b1, 1'b0, 1'b0);
    chk("gap writes", 32'(wr_cnt - w0), 32'd2);

    // Single word; a trailing byte after completion must be ignored.
    w0 = wr_cnt;
    build_one();
    run_vecs("one", 0);
    post("one", 1'b1, 1'b0, 1'b0);
    add(8'h77, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_vecs("trail", 0);
    chk("one writes", 32'(wr_cnt - w0), 32'd1);

    // Asynchronous reset after the first data word of a frame.
    add(8'hA5, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    add(8'h00, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    add(8'h02, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    add(8'hC0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    add(8'h1F, 1'b1, 16'h0000, 16'hC01F, 1'b0, 1'b1, 1'b0);
    run_vecs("midrst", 0);
    @(negedge clock);
    chk("midrst addr advanced", 32'(mem_addr), 32'h0001);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst cpu_hold", 32'(cpu_hold), 32'd1);
    chk("midrst mem_addr", 32'(mem_addr), 32'h0000);
    chk("midrst mem_wdata", 32'(mem_wdata), 32'h0000);
    chk("midrst rx_ready", 32'(rx_ready), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    add(8'h12, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    build_one();
    run_vecs("restart", 0);
    post("restart", 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
